// File: rtl/contador_faixa_pkg.sv
// Shared constants for the up/down range counter: direction and mode encodings, default widths.
// Imported by the interface, the top and the bench.
package contador_faixa_pkg;
   localparam logic DIR_UP      = 1'b1;
   localparam logic DIR_DOWN    = 1'b0;
   localparam logic MODE_WRAP   = 1'b1;
   localparam logic MODE_SAT    = 1'b0;
   localparam int   N_DEF       = 16;
   localparam int   PRESC_W_DEF = 8;
endpackage

// File: rtl/contador_faixa_if.sv
// Control/bound inputs and status outputs of the range counter, bundled with master/slave views.
// presc_div exists only when CONTADOR_FAIXA_PRESCALER_EN is defined.
interface contador_faixa_if #(
   parameter int N = contador_faixa_pkg::N_DEF
`ifdef CONTADOR_FAIXA_PRESCALER_EN
   , parameter int PRESC_W = contador_faixa_pkg::PRESC_W_DEF
`endif
);
   logic         clr;
   logic         ld;
   logic         ent;
   logic         enp;
   logic         up;
   logic [N-1:0] step;
   logic [N-1:0] D;
   logic [N-1:0] min_val;
   logic [N-1:0] max_val;
   logic         wrap;
`ifdef CONTADOR_FAIXA_PRESCALER_EN
   logic [PRESC_W-1:0] presc_div;
`endif
   logic [N-1:0] Q;
   logic         rco;
   logic         tc;
   logic         at_min;
   logic         at_max;
   logic         cfg_err;

   modport master (
`ifdef CONTADOR_FAIXA_PRESCALER_EN
      output presc_div,
`endif
      output clr, ld, ent, enp, up, step, D, min_val, max_val, wrap,
      input  Q, rco, tc, at_min, at_max, cfg_err
   );

   modport slave (
`ifdef CONTADOR_FAIXA_PRESCALER_EN
      input  presc_div,
`endif
      input  clr, ld, ent, enp, up, step, D, min_val, max_val, wrap,
      output Q, rco, tc, at_min, at_max, cfg_err
   );
endinterface

// File: rtl/contador_faixa_presc.sv
// Step prescaler: tick on the enabled cycle where the count equals div, then restart from 0.
// Dropping en freezes the count; clr or reset returns it to 0.
module contador_faixa_presc #(
   parameter int PRESC_W = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               en,
   input  logic               clr,
   input  logic [PRESC_W-1:0] div,
   output logic               tick
);
   logic [PRESC_W-1:0] cnt_q, cnt_d;

   assign tick = en && (cnt_q == div);

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en)
         cnt_d = tick ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end
endmodule

// File: rtl/contador_faixa.sv
// Up/down range counter with programmable bounds, step and wrap/saturate; Q always lands in range.
// Optional step prescaler enabled by CONTADOR_FAIXA_PRESCALER_EN.
module contador_faixa
   import contador_faixa_pkg::*;
#(
   parameter int N = N_DEF
`ifdef CONTADOR_FAIXA_PRESCALER_EN
   , parameter int PRESC_W = PRESC_W_DEF
`endif
) (
   input  logic            clock,
   input  logic            reset,
   contador_faixa_if.slave bus
);
   logic [N-1:0] q_q, q_d;
   logic         tc_q, tc_d;
   logic [N-1:0] q_clamp, d_clamp, q_step, term;
   logic [N:0]   sum_e, lim_e;
   logic         cfg_err, ld_ok, en_cnt, tick, do_step;
   logic         wrapped, hit, pinned;

   assign cfg_err = bus.min_val > bus.max_val;
   assign ld_ok   = bus.ld && !cfg_err;
   assign en_cnt  = bus.ent && bus.enp && !cfg_err;
   assign pinned  = bus.min_val == bus.max_val;
   assign term    = (bus.up == DIR_UP) ? bus.max_val : bus.min_val;

`ifdef CONTADOR_FAIXA_PRESCALER_EN
   contador_faixa_presc #(.PRESC_W(PRESC_W)) u_presc (
      .clock (clock),
      .reset (reset),
      .en    (en_cnt && !bus.clr && !ld_ok),
      .clr   (bus.clr || ld_ok),
      .div   (bus.presc_div),
      .tick  (tick)
   );
`else
   assign tick = 1'b1;
`endif

   assign do_step = en_cnt && tick && (bus.step != '0);

   // Step arithmetic in N+1 bits so neither direction can silently wrap modulo 2^N.
   always_comb begin
      q_clamp = q_q;
      if (q_q < bus.min_val)
         q_clamp = bus.min_val;
      else if (q_q > bus.max_val)
         q_clamp = bus.max_val;

      d_clamp = bus.D;
      if (bus.D < bus.min_val)
         d_clamp = bus.min_val;
      else if (bus.D > bus.max_val)
         d_clamp = bus.max_val;

      sum_e   = {1'b0, q_clamp} + {1'b0, bus.step};
      lim_e   = {1'b0, bus.min_val} + {1'b0, bus.step};
      q_step  = q_clamp;
      wrapped = 1'b0;
      if (bus.up == DIR_UP) begin
         if (sum_e > {1'b0, bus.max_val}) begin
            q_step  = (bus.wrap == MODE_WRAP) ? bus.min_val : bus.max_val;
            wrapped = (bus.wrap == MODE_WRAP);
         end else begin
            q_step = sum_e[N-1:0];
         end
      end else begin
         if ({1'b0, q_clamp} < lim_e) begin
            q_step  = (bus.wrap == MODE_WRAP) ? bus.max_val : bus.min_val;
            wrapped = (bus.wrap == MODE_WRAP);
         end else begin
            q_step = q_clamp - bus.step;
         end
      end
      hit = q_step == term;
   end

   // A single-value range behaves as saturate: only arrival at the bound pulses tc.
   always_comb begin
      q_d  = q_q;
      tc_d = 1'b0;
      if (bus.clr) begin
         q_d = bus.min_val;
      end else if (ld_ok) begin
         q_d = d_clamp;
      end else if (do_step) begin
         q_d  = q_step;
         tc_d = (wrapped && !pinned) || (hit && (q_q != term));
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         q_q  <= '0;
         tc_q <= 1'b0;
      end else begin
         q_q  <= q_d;
         tc_q <= tc_d;
      end
   end

   assign bus.Q       = q_q;
   assign bus.tc      = tc_q;
   assign bus.rco     = bus.ent && (q_q == term);
   assign bus.at_min  = q_q == bus.min_val;
   assign bus.at_max  = q_q == bus.max_val;
   assign bus.cfg_err = cfg_err;
endmodule

// File: tb/tb_contador_faixa.sv
// Directed bench for contador_faixa at N=8: expected Q/tc pushed per driven cycle, popped after the edge.
module tb_contador_faixa;
   import contador_faixa_pkg::*;

   localparam int W = 8;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   contador_faixa_if #(
      .N(W)
`ifdef CONTADOR_FAIXA_PRESCALER_EN
      , .PRESC_W(8)
`endif
   ) bus ();

   contador_faixa #(
      .N(W)
`ifdef CONTADOR_FAIXA_PRESCALER_EN
      , .PRESC_W(8)
`endif
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [W-1:0] q;
      logic         tc;
      string        tag;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Queue the expected post-edge state, clock once, then drain and compare.
   task automatic exp_step(input logic [W-1:0] q, input logic tc, input string tag);
      exp_t e;
      e.q = q;
      e.tc = tc;
      e.tag = tag;
      sb.push_back(e);
      @(posedge clock);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         chk({e.tag, " Q"}, bus.Q, e.q);
         chk({e.tag, " tc"}, W'(bus.tc), W'(e.tc));
      end
   endtask

   initial begin
      reset       = 1'b1;
      bus.clr     = 1'b0;
      bus.ld      = 1'b0;
      bus.ent     = 1'b0;
      bus.enp     = 1'b0;
      bus.up      = DIR_UP;
      bus.step    = 8'd3;
      bus.D       = 8'd0;
      bus.min_val = 8'd2;
      bus.max_val = 8'd9;
      bus.wrap    = MODE_WRAP;
`ifdef CONTADOR_FAIXA_PRESCALER_EN
      bus.presc_div = 8'd0;
`endif
      exp_step(8'd0, 1'b0, "reset");
      chk("reset at_min", W'(bus.at_min), 8'd0);
      chk("reset cfg_err", W'(bus.cfg_err), 8'd0);

      // Wrap up: 2,5,8,2,5 with tc only after 8->2
      reset = 1'b0;
      bus.clr = 1'b1;
      exp_step(8'd2, 1'b0, "clr");
      chk("clr at_min", W'(bus.at_min), 8'd1);
      bus.clr = 1'b0;
      bus.ent = 1'b1;
      bus.enp = 1'b1;
      exp_step(8'd5, 1'b0, "wrap_up1");
      exp_step(8'd8, 1'b0, "wrap_up2");
      exp_step(8'd2, 1'b1, "wrap_up3");
      exp_step(8'd5, 1'b0, "wrap_up4");

      // Saturate up from 8
      bus.wrap = MODE_SAT;
      bus.ld = 1'b1;
      bus.D = 8'd8;
      exp_step(8'd8, 1'b0, "ld8");
      bus.ld = 1'b0;
      exp_step(8'd9, 1'b1, "sat_arrive");
      repeat (3) exp_step(8'd9, 1'b0, "sat_pinned");
      chk("sat rco", W'(bus.rco), 8'd1);
      chk("sat at_max", W'(bus.at_max), 8'd1);

      // Down wrap from 5 with step 4
      bus.wrap = MODE_WRAP;
      bus.step = 8'd4;
      bus.ld = 1'b1;
      bus.D = 8'd5;
      exp_step(8'd5, 1'b0, "ld5");
      bus.ld = 1'b0;
      bus.up = DIR_DOWN;
      exp_step(8'd9, 1'b1, "down_wrap");
      exp_step(8'd5, 1'b0, "down_step");

      // Load clamping and clr priority
      bus.ent = 1'b0;
      bus.enp = 1'b0;
      bus.ld = 1'b1;
      bus.D = 8'd20;
      exp_step(8'd9, 1'b0, "ld_hi_clamp");
      bus.D = 8'd0;
      exp_step(8'd2, 1'b0, "ld_lo_clamp");
      chk("ld_lo at_min", W'(bus.at_min), 8'd1);
      chk("rco ent low", W'(bus.rco), 8'd0);
      bus.ent = 1'b1;
      #1;
      chk("rco down at min", W'(bus.rco), 8'd1);
      bus.ent = 1'b0;
      bus.D = 8'd5;
      bus.clr = 1'b1;
      exp_step(8'd2, 1'b0, "ld_with_clr");
      bus.clr = 1'b0;

      // Inverted bounds: ld and steps ignored, clr still loads min_val
      bus.min_val = 8'd10;
      bus.max_val = 8'd4;
      #1;
      chk("cfg_err set", W'(bus.cfg_err), 8'd1);
      bus.D = 8'd7;
      bus.ent = 1'b1;
      bus.enp = 1'b1;
      bus.up = DIR_UP;
      bus.step = 8'd1;
      exp_step(8'd2, 1'b0, "cfg_ld");
      bus.ld = 1'b0;
      exp_step(8'd2, 1'b0, "cfg_step");
      bus.clr = 1'b1;
      exp_step(8'd10, 1'b0, "cfg_clr");
      bus.clr = 1'b0;

      // Out-of-range start: step 0 holds, then a down step clamps first
      bus.min_val = 8'd2;
      bus.max_val = 8'd9;
      bus.step = 8'd0;
      exp_step(8'd10, 1'b0, "step0_hold");
      bus.step = 8'd1;
      bus.up = DIR_DOWN;
      bus.wrap = MODE_SAT;
      exp_step(8'd8, 1'b0, "clamp_down");

      // Single-value range with wrap: pinned, no tc
      bus.min_val = 8'd5;
      bus.max_val = 8'd5;
      bus.wrap = MODE_WRAP;
      bus.up = DIR_UP;
      bus.clr = 1'b1;
      exp_step(8'd5, 1'b0, "pin_clr");
      bus.clr = 1'b0;
      exp_step(8'd5, 1'b0, "pin_step1");
      exp_step(8'd5, 1'b0, "pin_step2");
      chk("pin at_min", W'(bus.at_min), 8'd1);
      chk("pin at_max", W'(bus.at_max), 8'd1);
      chk("pin rco", W'(bus.rco), 8'd1);

      // Reset beats a simultaneous load
      reset = 1'b1;
      bus.ld = 1'b1;
      bus.D = 8'd7;
      exp_step(8'd0, 1'b0, "reset_vs_ld");
      reset = 1'b0;
      bus.ld = 1'b0;

`ifdef CONTADOR_FAIXA_PRESCALER_EN
      // Divide by 3, pause enp mid-count without losing phase
      bus.min_val = 8'd0;
      bus.max_val = 8'd255;
      bus.step = 8'd1;
      bus.up = DIR_UP;
      bus.wrap = MODE_SAT;
      bus.presc_div = 8'd2;
      bus.clr = 1'b1;
      exp_step(8'd0, 1'b0, "presc_clr");
      bus.clr = 1'b0;
      exp_step(8'd0, 1'b0, "presc_c1");
      exp_step(8'd0, 1'b0, "presc_c2");
      exp_step(8'd1, 1'b0, "presc_c3");
      exp_step(8'd1, 1'b0, "presc_c4");
      exp_step(8'd1, 1'b0, "presc_c5");
      exp_step(8'd2, 1'b0, "presc_c6");
      exp_step(8'd2, 1'b0, "presc_c7");
      bus.enp = 1'b0;
      repeat (5) exp_step(8'd2, 1'b0, "presc_paused");
      bus.enp = 1'b1;
      exp_step(8'd2, 1'b0, "presc_resume1");
      exp_step(8'd3, 1'b0, "presc_resume2");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/contador_faixa.md
# contador_faixa

Parametrised up/down range counter with programmable lower and upper bounds, step size, and wrap-or-saturate mode. It supersedes the fixed-direction max-limited counter used for difficulty selection. It drives difficulty level, spawn-rate, and score-tier indices, where the bound and direction change at runtime. Q never leaves [min_val, max_val] after a load or count step.

## Interface
- N, 16, counter/bound/step width
- PRESC_W, 8, prescaler divisor width (used only with CONTADOR_FAIXA_PRESCALER_EN)
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- clr  in  1  synchronous clear to min_val
- ld  in  1  synchronous load of D, clamped to range
- ent, enp  in  1 each  count enables; a step is requested only when both are high
- up  in  1  direction: 1 = count up, 0 = count down
- step  in  N  increment magnitude
- D  in  N  load value
- min_val, max_val  in  N each  inclusive bounds
- wrap  in  1  1 = wrap to the opposite bound, 0 = saturate at the bound
- presc_div  in  PRESC_W  steps occur every presc_div+1 enabled cycles (macro only)
- Q  out  N  count value
- rco  out  1  combinational: ent && Q at the terminal bound for the current direction
- tc  out  1  registered one-cycle terminal pulse
- at_min, at_max  out  1 each  combinational: Q == min_val, Q == max_val
- cfg_err  out  1  combinational: min_val > max_val

## Operation
- Priority: reset > clr > ld > count step > hold.
- reset: Q=0, tc=0, prescaler=0.
- clr: Q=min_val, tc=0, prescaler=0.
- ld: Q = D<min_val ? min_val : D>max_val ? max_val : D. tc=0. prescaler=0.
- Count step when ent && enp (and prescaler tick when the macro is set). All arithmetic uses N+1 bits; there is no silent modular overflow.
- Up: s=Q+step.
  - If s>max_val: Q = wrap ? min_val : max_val.
  - Otherwise Q=s.
- Down: if Q < min_val+step (computed in N+1 bits): Q = wrap ? max_val : min_val. Otherwise Q=Q-step.
- A step whose start value Q lies outside the range (only possible after reset or a bound change) first clamps Q into range, then applies the step.
- step==0: Q holds and tc stays low.
- cfg_err high: Q holds, count steps and ld are ignored; clr still loads min_val.
- tc=1 in the cycle after a step that lands on the terminal bound or wraps.
  - Saturate mode: tc fires once on arrival. Further steps while pinned at the bound do not re-fire it.
  - Wrap mode: tc fires on every wrap.
- min_val==max_val: Q pinned at that value. tc behaves as in saturate mode regardless of wrap.

## Timing
- Q, tc, and the prescaler update on the rising edge of clock. The latency from an input to Q is 1 cycle.
- rco, at_min, at_max, and cfg_err are combinational from Q and the inputs, with no cycle delay.
- tc is high for exactly 1 cycle. The earliest tc is the cycle after the first qualifying step.
- Bound, step, up, or wrap changes take effect on the next edge; no handshake is required.
- reset or clr in the same cycle as ld or a step: reset or clr wins, and no tc is produced.

## Configuration
- CONTADOR_FAIXA_PRESCALER_EN defined:
  - presc_div port and an internal PRESC_W-bit prescaler are present.
  - The prescaler advances on ent && enp. A step is taken when prescaler==presc_div, and the prescaler then returns to 0.
  - presc_div=0 gives a step every enabled cycle.
  - Dropping ent or enp freezes the prescaler; it does not clear it.
- Undefined: no presc_div port and no prescaler; every enabled cycle is a step.

## Structure
- Package contador_faixa_pkg holds:
  - DIR_UP=1'b1, DIR_DOWN=1'b0
  - MODE_WRAP=1'b1, MODE_SAT=1'b0
  - default N=16 and PRESC_W=8
- Sub-module contador_faixa_presc (prescaler: enable in, clear in, divisor in, tick out). It is instantiated only under the macro.

## Test plan
- N=8, min=2, max=9, step=3, up, wrap=1, clr then 4 steps → Q: 2,5,8,2,5. tc high only the cycle after the 8→2 step.
- Same bounds, wrap=0, up, from Q=8: step → Q=9, tc pulses once. 3 more steps → Q stays 9, tc low, rco=1, at_max=1.
- Down, wrap=1, min=2, max=9, step=4, Q=5: step → Q=9, tc=1. Next step → Q=5.
- ld with D=20, min=2, max=9 → Q=9. ld with D=0 → Q=2. ld together with clr → Q=min_val.
- min=10, max=4: cfg_err=1. ld and steps leave Q unchanged; clr → Q=10.
- Macro set, presc_div=2, continuous enable, step=1 from Q=0, range 0..255 → Q increments every 3rd cycle. Deasserting enp for 5 cycles mid-count resumes without losing the prescaler phase.
